multicycle_control_fsm: RTL and testbench
=========================================

MULTICYCLE_CONTROL_FSM -- requirements
Module: multicycle_control_fsm

Interface
REQ-001 SHALL have port: clk  input  1  single system clock; all state changes on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: opcode  input  4  instruction bits [15:12], from the datapath's instruction register.
REQ-004 SHALL have port: funct  input  4  instruction bits [3:0], from the instruction register.
REQ-005 SHALL have port: zero  input  1  ALU zero flag.
REQ-006 SHALL have port: mem_ready  input  1  memory transfer-complete strobe.
REQ-007 SHALL have ports, all outputs: mem_req 1, mem_we 1, mem_addr_sel 1 (0=PC, 1=ALU result), ir_write 1, pc_write 1, pc_src 2 (00=PC+2, 01=branch target, 10=jump target), alu_op 4, alu_src_a 1 (0=PC, 1=rs), alu_src_b 2 (00=rt, 01=imm, 10=const 2), reg_write 1, mem_to_reg 1.
REQ-008 SHALL have ports, all outputs: state 3 (current state), trap 1 (sticky illegal-instruction flag), retire 1 (one-cycle pulse per completed instruction), retired_count 16 (completed-instruction count).

Function
REQ-009 SHALL implement states FETCH, DECODE, EXEC, MEM, WB, TRAP.
REQ-010 SHALL drive every output not listed for the current state to 0.
REQ-011 FETCH SHALL assert mem_req=1 with mem_addr_sel=0, and SHALL stay in FETCH while mem_ready=0.
REQ-012 In FETCH with mem_ready=1, SHALL assert ir_write=1 and pc_write=1 with pc_src=00, and SHALL go to DECODE.
REQ-013 DECODE SHALL last exactly 1 cycle, with alu_src_a=0, alu_src_b=01 and alu_op=0000, to form the branch target.
REQ-014 In DECODE, opcodes 0111-1111, and opcode 0000 with funct > 0011, SHALL go to TRAP; all other opcodes SHALL go to EXEC.
REQ-015 EXEC with opcode 0000 SHALL drive alu_op=funct, alu_src_a=1 and alu_src_b=00, then go to WB.
REQ-016 EXEC with opcode 0001 (load), 0010 (store) or 0011 (addi) SHALL drive alu_op=0000, alu_src_a=1 and alu_src_b=01.
REQ-017 From EXEC, load and store SHALL go to MEM, and addi SHALL go to WB.
REQ-018 EXEC with opcode 0100 (beq) or 0101 (bne) SHALL drive alu_op=0001, alu_src_a=1 and alu_src_b=00.
REQ-019 For beq/bne, SHALL assert pc_write=1 with pc_src=01 only when zero=1 (beq) or zero=0 (bne), then go to FETCH.
REQ-020 EXEC with opcode 0110 (jump) SHALL assert pc_write=1 with pc_src=10, then go to FETCH.
REQ-021 MEM SHALL assert mem_req=1 and mem_addr_sel=1, and SHALL assert mem_we=1 only for store.
REQ-022 SHALL stay in MEM while mem_ready=0.
REQ-023 MEM with mem_ready=1 SHALL go to FETCH for store and to WB for load.
REQ-024 WB SHALL assert reg_write=1, with mem_to_reg=1 for load and 0 otherwise, then go to FETCH.
REQ-025 retire SHALL pulse in the cycle an instruction leaves its last state: WB, EXEC for branch/jump, MEM for store.
REQ-026 retired_count SHALL increment by 1 on each retire and SHALL wrap from 0xFFFF to 0x0000.
REQ-027 TRAP SHALL be absorbing with trap=1 and all other control outputs 0; only rst SHALL exit it.
REQ-028 SHALL ignore mem_ready when mem_req=0.
REQ-029 SHALL treat opcode/funct as stable from DECODE through the instruction's last state.
REQ-030 Latency SHALL be, with zero-wait memory: R-type/addi 4 cycles, load 5, store 4, branch/jump 3.

Reset
REQ-031 While rst=1, SHALL hold all outputs 0, including mem_req, trap and retire.
REQ-032 On the first clk edge with rst=1, SHALL set state to FETCH, clear trap and clear retired_count, overriding any state, including a mid-MEM wait.
REQ-033 In the first cycle after rst falls, SHALL be in FETCH and SHALL assert mem_req.

Structure
REQ-034 SHALL take the state encoding, opcode constants (0000-0110), ALU op constants, and pc_src/alu_src_b encodings from the shared package cpu16_ctrl_pkg.
REQ-035 SHALL place opcode/funct classification (rtype, load, store, addi, beq, bne, jump, illegal) in combinational sub-module ctrl_op_decode.

Verification
REQ-036 SHALL cover: rst, then R-type opcode 0000 funct 0010 with mem_ready=1 in its first FETCH cycle -> states FETCH, DECODE, EXEC, WB; alu_op=0010 in EXEC; reg_write=1 in WB; retire pulse; retired_count=1.
REQ-037 SHALL cover: load opcode 0001 with mem_ready held low 3 cycles in MEM -> mem_req=1, mem_addr_sel=1 and mem_we=0 for 4 cycles; then WB with mem_to_reg=1.
REQ-038 SHALL cover: beq (0100) with zero=1 -> pc_write=1 and pc_src=01 in EXEC; bne (0101) with zero=1 -> pc_write=0; both go to FETCH next.
REQ-039 SHALL cover: opcode 1001, and opcode 0000 with funct 0110 -> TRAP after DECODE, trap=1 held 10 cycles, then rst -> trap=0 and state FETCH.
REQ-040 SHALL cover: rst asserted mid-MEM of a store -> mem_req=0 and mem_we=0 while rst=1, and no retire pulse.
REQ-041 SHALL cover: 65536 jump (0110) instructions -> retired_count wraps to 0x0000.

Source files
------------

// File: rtl/cpu16_ctrl_pkg.sv
// Shared encodings for the 16-bit multicycle CPU control path: states,
// opcodes, ALU ops, mux selects and the decoded-instruction class bundle.
package cpu16_ctrl_pkg;

    localparam int unsigned STATE_W  = 3;
    localparam int unsigned OPCODE_W = 4;
    localparam int unsigned FUNCT_W  = 4;
    localparam int unsigned ALU_OP_W = 4;
    localparam int unsigned SEL_W    = 2;
    localparam int unsigned COUNT_W  = 16;

    typedef enum logic [STATE_W-1:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 4'h0;
    localparam logic [OPCODE_W-1:0] OP_LOAD  = 4'h1;
    localparam logic [OPCODE_W-1:0] OP_STORE = 4'h2;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 4'h3;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 4'h4;
    localparam logic [OPCODE_W-1:0] OP_BNE   = 4'h5;
    localparam logic [OPCODE_W-1:0] OP_JUMP  = 4'h6;

    // Highest funct code implemented by the ALU for R-type instructions.
    localparam logic [FUNCT_W-1:0] FUNCT_MAX = 4'h3;

    localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'h0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'h1;

    localparam logic [SEL_W-1:0] PC_SRC_SEQ    = 2'b00;
    localparam logic [SEL_W-1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [SEL_W-1:0] PC_SRC_JUMP   = 2'b10;

    localparam logic [SEL_W-1:0] ALU_B_RT  = 2'b00;
    localparam logic [SEL_W-1:0] ALU_B_IMM = 2'b01;
    localparam logic [SEL_W-1:0] ALU_B_TWO = 2'b10;

    typedef struct packed {
        logic rtype;
        logic load;
        logic store;
        logic addi;
        logic beq;
        logic bne;
        logic jump;
        logic illegal;
    } op_class_t;

    typedef struct packed {
        logic                mem_req;
        logic                mem_we;
        logic                mem_addr_sel;
        logic                ir_write;
        logic                pc_write;
        logic [SEL_W-1:0]    pc_src;
        logic [ALU_OP_W-1:0] alu_op;
        logic                alu_src_a;
        logic [SEL_W-1:0]    alu_src_b;
        logic                reg_write;
        logic                mem_to_reg;
    } ctrl_t;

endpackage

// File: rtl/ctrl_op_decode.sv
// Combinational classification of the instruction register opcode/funct.
module ctrl_op_decode
    import cpu16_ctrl_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [FUNCT_W-1:0]  funct,
    output op_class_t           op_class_c
);

    always_comb begin
        op_class_c       = '0;
        op_class_c.rtype = (opcode == OP_RTYPE) && (funct <= FUNCT_MAX);
        op_class_c.load  = (opcode == OP_LOAD);
        op_class_c.store = (opcode == OP_STORE);
        op_class_c.addi  = (opcode == OP_ADDI);
        op_class_c.beq   = (opcode == OP_BEQ);
        op_class_c.bne   = (opcode == OP_BNE);
        op_class_c.jump  = (opcode == OP_JUMP);
        // Unused opcodes and unimplemented R-type functs both trap.
        op_class_c.illegal = (opcode > OP_JUMP) ||
                             ((opcode == OP_RTYPE) && (funct > FUNCT_MAX));
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle CPU control unit: sequences fetch/decode/execute/memory/writeback
// and drives datapath mux selects, strobes and the retired-instruction count.
module multicycle_control_fsm
    import cpu16_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [FUNCT_W-1:0]  funct,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                mem_we,
    output logic                mem_addr_sel,
    output logic                ir_write,
    output logic                pc_write,
    output logic [SEL_W-1:0]    pc_src,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                alu_src_a,
    output logic [SEL_W-1:0]    alu_src_b,
    output logic                reg_write,
    output logic                mem_to_reg,
    output logic [STATE_W-1:0]  state,
    output logic                trap,
    output logic                retire,
    output logic [COUNT_W-1:0]  retired_count
);

    state_t             state_q;
    state_t             state_d;
    logic               trap_q;
    logic [COUNT_W-1:0] count_q;
    op_class_t          op_class_c;
    ctrl_t              ctrl_c;
    logic               retire_c;

    ctrl_op_decode u_decode (
        .opcode     (opcode),
        .funct      (funct),
        .op_class_c (op_class_c)
    );

    // State, sticky trap flag and retired-instruction counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
            trap_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            trap_q  <= trap_q | (state_d == ST_TRAP);
            if (retire_c) begin
                count_q <= count_q + COUNT_W'(1);
            end
        end
    end

    // Next-state and per-state control outputs; reset forces everything low.
    always_comb begin
        state_d  = state_q;
        ctrl_c   = '0;
        retire_c = 1'b0;

        case (state_q)
            ST_FETCH: begin
                ctrl_c.mem_req = 1'b1;
                if (mem_ready) begin
                    ctrl_c.ir_write = 1'b1;
                    ctrl_c.pc_write = 1'b1;
                    ctrl_c.pc_src   = PC_SRC_SEQ;
                    state_d         = ST_DECODE;
                end
            end

            ST_DECODE: begin
                ctrl_c.alu_src_a = 1'b0;
                ctrl_c.alu_src_b = ALU_B_IMM;
                ctrl_c.alu_op    = ALU_ADD;
                state_d          = op_class_c.illegal ? ST_TRAP : ST_EXEC;
            end

            ST_EXEC: begin
                if (op_class_c.rtype) begin
                    ctrl_c.alu_op    = funct;
                    ctrl_c.alu_src_a = 1'b1;
                    ctrl_c.alu_src_b = ALU_B_RT;
                    state_d          = ST_WB;
                end else if (op_class_c.load || op_class_c.store || op_class_c.addi) begin
                    ctrl_c.alu_op    = ALU_ADD;
                    ctrl_c.alu_src_a = 1'b1;
                    ctrl_c.alu_src_b = ALU_B_IMM;
                    state_d          = op_class_c.addi ? ST_WB : ST_MEM;
                end else if (op_class_c.beq || op_class_c.bne) begin
                    ctrl_c.alu_op    = ALU_SUB;
                    ctrl_c.alu_src_a = 1'b1;
                    ctrl_c.alu_src_b = ALU_B_RT;
                    if ((op_class_c.beq && zero) || (op_class_c.bne && !zero)) begin
                        ctrl_c.pc_write = 1'b1;
                        ctrl_c.pc_src   = PC_SRC_BRANCH;
                    end
                    retire_c = 1'b1;
                    state_d  = ST_FETCH;
                end else if (op_class_c.jump) begin
                    ctrl_c.pc_write = 1'b1;
                    ctrl_c.pc_src   = PC_SRC_JUMP;
                    retire_c        = 1'b1;
                    state_d         = ST_FETCH;
                end else begin
                    state_d = ST_TRAP;
                end
            end

            ST_MEM: begin
                ctrl_c.mem_req      = 1'b1;
                ctrl_c.mem_addr_sel = 1'b1;
                ctrl_c.mem_we       = op_class_c.store;
                if (mem_ready) begin
                    retire_c = op_class_c.store;
                    state_d  = op_class_c.store ? ST_FETCH : ST_WB;
                end
            end

            ST_WB: begin
                ctrl_c.reg_write  = 1'b1;
                ctrl_c.mem_to_reg = op_class_c.load;
                retire_c          = 1'b1;
                state_d           = ST_FETCH;
            end

            ST_TRAP: begin
                state_d = ST_TRAP;
            end

            default: begin
                state_d = ST_FETCH;
            end
        endcase

        if (rst) begin
            ctrl_c   = '0;
            retire_c = 1'b0;
        end
    end

    assign mem_req       = ctrl_c.mem_req;
    assign mem_we        = ctrl_c.mem_we;
    assign mem_addr_sel  = ctrl_c.mem_addr_sel;
    assign ir_write      = ctrl_c.ir_write;
    assign pc_write      = ctrl_c.pc_write;
    assign pc_src        = ctrl_c.pc_src;
    assign alu_op        = ctrl_c.alu_op;
    assign alu_src_a     = ctrl_c.alu_src_a;
    assign alu_src_b     = ctrl_c.alu_src_b;
    assign reg_write     = ctrl_c.reg_write;
    assign mem_to_reg    = ctrl_c.mem_to_reg;
    assign retire        = retire_c;
    assign state         = rst ? STATE_W'(0) : STATE_W'(state_q);
    assign trap          = trap_q & ~rst;
    assign retired_count = rst ? COUNT_W'(0) : count_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed-vector bench for multicycle_control_fsm with immediate assertions.
module tb_multicycle_control_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  opcode;
    logic [3:0]  funct;
    logic        zero;
    logic        mem_ready;
    logic        mem_req, mem_we, mem_addr_sel, ir_write, pc_write;
    logic [1:0]  pc_src;
    logic [3:0]  alu_op;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic        reg_write, mem_to_reg;
    logic [2:0]  state;
    logic        trap, retire;
    logic [15:0] retired_count;

    int n_assert = 0;
    int n_fail   = 0;

    localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
                           S_MEM = 3'd3, S_WB = 3'd4, S_TRAP = 3'd5;

    multicycle_control_fsm dut (
        .clk           (clk),
        .rst           (rst),
        .opcode        (opcode),
        .funct         (funct),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr_sel  (mem_addr_sel),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_src        (pc_src),
        .alu_op        (alu_op),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .reg_write     (reg_write),
        .mem_to_reg    (mem_to_reg),
        .state         (state),
        .trap          (trap),
        .retire        (retire),
        .retired_count (retired_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1; opcode = 4'h0; funct = 4'h0; zero = 1'b0; mem_ready = 1'b1;
        tick(); tick();
        settle();
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_trap", 32'(trap), 0);
        chk("rst_retire", 32'(retire), 0);
        chk("rst_state", 32'(state), 0);
        chk("rst_count", 32'(retired_count), 0);
        chk("rst_ir_write", 32'(ir_write), 0);

        // R-type funct 0010, zero-wait fetch
        rst = 1'b0; opcode = 4'h0; funct = 4'h2; settle();
        chk("r_fetch_state", 32'(state), 32'(S_FETCH));
        chk("r_fetch_mem_req", 32'(mem_req), 1);
        chk("r_fetch_addr_sel", 32'(mem_addr_sel), 0);
        chk("r_fetch_ir_write", 32'(ir_write), 1);
        chk("r_fetch_pc_write", 32'(pc_write), 1);
        chk("r_fetch_pc_src", 32'(pc_src), 0);
        tick();
        chk("r_dec_state", 32'(state), 32'(S_DECODE));
        chk("r_dec_src_a", 32'(alu_src_a), 0);
        chk("r_dec_src_b", 32'(alu_src_b), 1);
        chk("r_dec_alu_op", 32'(alu_op), 0);
        chk("r_dec_mem_req", 32'(mem_req), 0);
        tick();
        chk("r_exec_state", 32'(state), 32'(S_EXEC));
        chk("r_exec_alu_op", 32'(alu_op), 2);
        chk("r_exec_src_a", 32'(alu_src_a), 1);
        chk("r_exec_src_b", 32'(alu_src_b), 0);
        chk("r_exec_retire", 32'(retire), 0);
        tick();
        chk("r_wb_state", 32'(state), 32'(S_WB));
        chk("r_wb_reg_write", 32'(reg_write), 1);
        chk("r_wb_mem_to_reg", 32'(mem_to_reg), 0);
        chk("r_wb_retire", 32'(retire), 1);
        tick();
        chk("r_done_state", 32'(state), 32'(S_FETCH));
        chk("r_done_count", 32'(retired_count), 1);
        chk("r_done_retire", 32'(retire), 0);

        // load with mem_ready low for 3 MEM cycles
        opcode = 4'h1; funct = 4'h0; settle();
        tick();
        chk("ld_dec_state", 32'(state), 32'(S_DECODE));
        tick();
        chk("ld_exec_state", 32'(state), 32'(S_EXEC));
        chk("ld_exec_src_b", 32'(alu_src_b), 1);
        chk("ld_exec_alu_op", 32'(alu_op), 0);
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 3) mem_ready = 1'b1;
            settle();
            chk("ld_mem_state", 32'(state), 32'(S_MEM));
            chk("ld_mem_req", 32'(mem_req), 1);
            chk("ld_mem_addr_sel", 32'(mem_addr_sel), 1);
            chk("ld_mem_we", 32'(mem_we), 0);
            chk("ld_mem_retire", 32'(retire), 0);
        end
        tick();
        chk("ld_wb_state", 32'(state), 32'(S_WB));
        chk("ld_wb_reg_write", 32'(reg_write), 1);
        chk("ld_wb_mem_to_reg", 32'(mem_to_reg), 1);
        tick();
        chk("ld_done_count", 32'(retired_count), 2);

        // beq taken with zero=1
        opcode = 4'h4; zero = 1'b1; settle();
        tick(); tick();
        chk("beq_exec_state", 32'(state), 32'(S_EXEC));
        chk("beq_pc_write", 32'(pc_write), 1);
        chk("beq_pc_src", 32'(pc_src), 1);
        chk("beq_alu_op", 32'(alu_op), 1);
        chk("beq_retire", 32'(retire), 1);
        tick();
        chk("beq_next_state", 32'(state), 32'(S_FETCH));
        chk("beq_count", 32'(retired_count), 3);

        // bne not taken with zero=1
        opcode = 4'h5; settle();
        tick(); tick();
        chk("bne_exec_state", 32'(state), 32'(S_EXEC));
        chk("bne_pc_write", 32'(pc_write), 0);
        chk("bne_retire", 32'(retire), 1);
        tick();
        chk("bne_next_state", 32'(state), 32'(S_FETCH));
        chk("bne_count", 32'(retired_count), 4);

        // store interrupted by reset while waiting in MEM
        opcode = 4'h2; zero = 1'b0; settle();
        tick(); tick();
        mem_ready = 1'b0;
        tick();
        chk("st_mem_state", 32'(state), 32'(S_MEM));
        chk("st_mem_we", 32'(mem_we), 1);
        chk("st_mem_req", 32'(mem_req), 1);
        tick();
        rst = 1'b1; mem_ready = 1'b1; settle();
        chk("st_rst_mem_req", 32'(mem_req), 0);
        chk("st_rst_mem_we", 32'(mem_we), 0);
        chk("st_rst_retire", 32'(retire), 0);
        tick();
        rst = 1'b0; settle();
        chk("st_after_rst_state", 32'(state), 32'(S_FETCH));
        chk("st_after_rst_mem_req", 32'(mem_req), 1);
        chk("st_after_rst_count", 32'(retired_count), 0);

        // illegal opcode 1001
        opcode = 4'h9; funct = 4'h0; settle();
        tick();
        chk("ill9_dec_state", 32'(state), 32'(S_DECODE));
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("ill9_trap_state", 32'(state), 32'(S_TRAP));
            chk("ill9_trap", 32'(trap), 1);
            chk("ill9_mem_req", 32'(mem_req), 0);
        end
        rst = 1'b1; tick();
        rst = 1'b0; settle();
        chk("ill9_rst_trap", 32'(trap), 0);
        chk("ill9_rst_state", 32'(state), 32'(S_FETCH));

        // R-type with unimplemented funct 0110
        opcode = 4'h0; funct = 4'h6; settle();
        tick();
        chk("ill_f6_dec_state", 32'(state), 32'(S_DECODE));
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("ill_f6_trap", 32'(trap), 1);
            chk("ill_f6_reg_write", 32'(reg_write), 0);
        end
        chk("ill_f6_state", 32'(state), 32'(S_TRAP));
        rst = 1'b1; tick();
        rst = 1'b0; settle();
        chk("ill_f6_rst_trap", 32'(trap), 0);
        chk("ill_f6_rst_state", 32'(state), 32'(S_FETCH));

        // 65536 jumps wrap the retired counter
        opcode = 4'h6; funct = 4'h0; settle();
        tick(); tick();
        chk("jmp_exec_state", 32'(state), 32'(S_EXEC));
        chk("jmp_pc_write", 32'(pc_write), 1);
        chk("jmp_pc_src", 32'(pc_src), 2);
        chk("jmp_retire", 32'(retire), 1);
        tick();
        chk("jmp_first_count", 32'(retired_count), 1);
        for (int i = 1; i < 65535; i++) begin
            tick(); tick(); tick();
        end
        chk("jmp_count_ffff", 32'(retired_count), 32'h0000_FFFF);
        chk("jmp_state_ffff", 32'(state), 32'(S_FETCH));
        tick(); tick(); tick();
        chk("jmp_count_wrap", 32'(retired_count), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
